// File: rtl/fifo_packet_writer.sv
// Write-side packet producer for asynchronous_fifo: forwards beats, then appends a count trailer word.
// Define FIFO_PKT_CSUM_EN to add an XOR checksum trailer word after the count.
module fifo_packet_writer #(
    parameter int DATA_SIZE = 32,
    parameter int CNT_W     = 16
) (
    input  logic                 wclk,
    input  logic                 w_rstn,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_SIZE-1:0] s_data,
    input  logic                 s_last,
    input  logic                 full,
    output logic                 w_en,
    output logic [DATA_SIZE-1:0] w_data,
    output logic [15:0]          pkt_count,
    output logic                 sat_err,
    output logic                 busy
);

`ifdef FIFO_PKT_CSUM_EN
    typedef enum logic [1:0] {DATA, TR_CNT, TR_SUM} state_t;
`else
    typedef enum logic [1:0] {DATA, TR_CNT} state_t;
`endif

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t               state;
    logic                 o_vld;
    logic [DATA_SIZE-1:0] o_data;
    logic [CNT_W-1:0]     cnt;
    logic                 slot_free;
    logic                 accept;
`ifdef FIFO_PKT_CSUM_EN
    logic [DATA_SIZE-1:0] csum;
`endif

    assign slot_free = ~o_vld | ~full;
    assign s_ready   = w_rstn & (state == DATA) & slot_free;
    assign accept    = s_valid & s_ready;
    assign w_en      = o_vld & ~full;
    assign w_data    = o_data;
    assign busy      = (state != DATA) | o_vld | (cnt != '0);

    always_ff @(posedge wclk) begin
        if (!w_rstn) begin
            state     <= DATA;
            o_vld     <= 1'b0;
            o_data    <= '0;
            cnt       <= '0;
            pkt_count <= '0;
            sat_err   <= 1'b0;
`ifdef FIFO_PKT_CSUM_EN
            csum      <= '0;
`endif
        end else begin
            // Drain first; a load below in the same cycle overrides this clear.
            if (w_en) begin
                o_vld <= 1'b0;
            end
            case (state)
                DATA: begin
                    if (accept) begin
                        o_vld  <= 1'b1;
                        o_data <= s_data;
                        if (cnt == CNT_MAX) begin
                            sat_err <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
`ifdef FIFO_PKT_CSUM_EN
                        csum <= csum ^ s_data;
`endif
                        if (s_last) begin
                            state <= TR_CNT;
                        end
                    end
                end
                TR_CNT: begin
                    if (slot_free) begin
                        o_vld  <= 1'b1;
                        o_data <= DATA_SIZE'(cnt);
`ifdef FIFO_PKT_CSUM_EN
                        state  <= TR_SUM;
`else
                        cnt       <= '0;
                        pkt_count <= pkt_count + 1'b1;
                        state     <= DATA;
`endif
                    end
                end
`ifdef FIFO_PKT_CSUM_EN
                TR_SUM: begin
                    if (slot_free) begin
                        o_vld     <= 1'b1;
                        o_data    <= csum;
                        cnt       <= '0;
                        csum      <= '0;
                        pkt_count <= pkt_count + 1'b1;
                        state     <= DATA;
                    end
                end
`endif
                default: state <= DATA;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_packet_writer.sv
// Bench for fifo_packet_writer: directed and random packets checked against a queue of expected FIFO writes.
`timescale 1ns/1ps
module tb_fifo_packet_writer;
    localparam int DW      = 32;
    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
`ifdef FIFO_PKT_CSUM_EN
    localparam int TRW = 2;
`else
    localparam int TRW = 1;
`endif

    logic          wclk = 1'b0;
    logic          w_rstn = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          full = 1'b0;
    logic          w_en;
    logic [DW-1:0] w_data;
    logic [15:0]   pkt_count;
    logic          sat_err;
    logic          busy;

    always #5 wclk = ~wclk;

    fifo_packet_writer #(.DATA_SIZE(DW), .CNT_W(CW)) dut (
        .wclk(wclk), .w_rstn(w_rstn), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_last(s_last), .full(full), .w_en(w_en),
        .w_data(w_data), .pkt_count(pkt_count), .sat_err(sat_err), .busy(busy)
    );

    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pkt[$];
    int            wr_cyc[$];
    int            cyc = 0;
    int            exp_pkts = 0;
    logic          exp_sat = 1'b0;
    int            pkt_n = 0;
    logic [DW-1:0] pkt_x = '0;
    int            full_mode = 0;   // 0: low, 1: high, 2: random
    int            stall_pct = 0;
    logic          smp_wen;
    logic          smp_ready;
    logic [DW-1:0] smp_wdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: a packet of n beats produces its beats, min(n, CNT_MAX), then the XOR of its beats.
    task automatic model_beat(input logic [DW-1:0] d, input logic last);
        exp_q.push_back(d);
        pkt_n++;
        pkt_x ^= d;
        if (last) begin
            exp_q.push_back(DW'((pkt_n > CNT_MAX) ? CNT_MAX : pkt_n));
`ifdef FIFO_PKT_CSUM_EN
            exp_q.push_back(pkt_x);
`endif
            if (pkt_n > CNT_MAX) exp_sat = 1'b1;
            exp_pkts = (exp_pkts + 1) % 65536;
            pkt_n = 0;
            pkt_x = '0;
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pkt_n = 0;
        pkt_x = '0;
        exp_pkts = 0;
        exp_sat = 1'b0;
    endtask

    // One clock: sample at negedge (checking any FIFO write), then return 1ns after posedge.
    task automatic step(output logic acc);
        case (full_mode)
            0: full = 1'b0;
            1: full = 1'b1;
            default: full = ($urandom_range(99) < stall_pct);
        endcase
        @(negedge wclk);
        smp_wen   = w_en;
        smp_wdata = w_data;
        smp_ready = s_ready;
        acc = s_valid && s_ready && w_rstn;
        if (w_rstn && w_en) begin
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("w_data", w_data, exp_q.pop_front());
            wr_cyc.push_back(cyc);
        end
        @(posedge wclk);
        #1;
        cyc++;
    endtask

    task automatic send_packet(input int gap_pct);
        logic acc;
        int   guard;
        for (int i = 0; i < pkt.size(); i++) begin
            while (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
                s_valid = 1'b0;
                step(acc);
            end
            s_valid = 1'b1;
            s_data  = pkt[i];
            s_last  = (i == pkt.size() - 1);
            acc = 1'b0;
            guard = 0;
            while (!acc && guard < 200) begin
                step(acc);
                guard++;
            end
            check("beat_accept", acc, 1);
            if (acc) model_beat(pkt[i], s_last);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        logic acc;
        int   guard;
        guard = 0;
        s_valid = 1'b0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && guard < 300) begin
            step(acc);
            guard++;
        end
        check("drain_done", guard < 300, 1);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   k0;
        int   k;

        // Reset state.
        full_mode = 0;
        step(acc);
        step(acc);
        check("rst_w_en", smp_wen, 0);
        check("rst_s_ready", smp_ready, 0);
        check("rst_w_data", w_data, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_sat_err", sat_err, 0);
        check("rst_busy", busy, 0);
        w_rstn = 1'b1;
        step(acc);

        // 3-beat packet with full low: consecutive writes of beats and trailer(s).
        k0 = wr_cyc.size();
        pkt = '{32'h11, 32'h22, 32'h44};
        send_packet(0);
        drain();
        k = wr_cyc.size();
        check("p1_write_count", k - k0, 3 + TRW);
        if (k - k0 == 3 + TRW) check("p1_consecutive", wr_cyc[k-1] - wr_cyc[k0], 2 + TRW);
        check("p1_pkt_count", pkt_count, 1);
        check("p1_busy", busy, 0);

        // full held for 4 cycles with a word pending.
        s_valid = 1'b1; s_data = 32'hC0DE0001; s_last = 1'b0;
        step(acc);
        check("hold_accept0", acc, 1);
        if (acc) model_beat(32'hC0DE0001, 1'b0);
        s_data = 32'hC0DE0002;
        full_mode = 1;
        for (int i = 0; i < 4; i++) begin
            step(acc);
            check("hold_w_en", smp_wen, 0);
            check("hold_w_data", smp_wdata, 32'hC0DE0001);
            check("hold_s_ready", smp_ready, 0);
        end
        full_mode = 0;
        step(acc);
        check("release_write", smp_wen, 1);
        check("release_accept", acc, 1);
        if (acc) model_beat(32'hC0DE0002, 1'b0);
        pkt = '{32'hC0DE0003};
        send_packet(0);
        drain();
        check("hold_pkt_count", pkt_count, exp_pkts);

        // Single-beat packets back to back.
        pkt = '{32'hA5};
        send_packet(0);
        pkt = '{32'h5A};
        send_packet(0);
        drain();
        check("single_pkt_count", pkt_count, exp_pkts);

        // Beat counter saturation, sticky through a later packet.
        pkt.delete();
        for (int i = 0; i < 17; i++) pkt.push_back($urandom);
        send_packet(0);
        drain();
        check("sat_err_set", sat_err, 1);
        pkt = '{32'h7, 32'h8};
        send_packet(0);
        drain();
        check("sat_err_sticky", sat_err, exp_sat);
        check("sat_pkt_count", pkt_count, exp_pkts);

        // Reset after two beats: pending word and trailer discarded.
        s_valid = 1'b1; s_data = 32'hDEAD0001; s_last = 1'b0;
        step(acc);
        if (acc) model_beat(32'hDEAD0001, 1'b0);
        s_data = 32'hDEAD0002;
        step(acc);
        if (acc) model_beat(32'hDEAD0002, 1'b0);
        s_valid = 1'b0;
        check("pre_reset_pending", exp_q.size(), 1);
        w_rstn = 1'b0;
        step(acc);
        step(acc);
        model_reset();
        check("mid_rst_w_en", smp_wen, 0);
        check("mid_rst_s_ready", smp_ready, 0);
        check("mid_rst_w_data", w_data, 0);
        check("mid_rst_pkt_count", pkt_count, 0);
        check("mid_rst_sat_err", sat_err, 0);
        check("mid_rst_busy", busy, 0);
        w_rstn = 1'b1;
        step(acc);
        pkt = '{32'h01, 32'h02};
        send_packet(0);
        drain();
        check("post_rst_pkt_count", pkt_count, 1);

        // Random packets with random full stalls and valid gaps.
        full_mode = 2;
        stall_pct = 30;
        for (int p = 0; p < 25; p++) begin
            pkt.delete();
            for (int i = 0; i < int'($urandom_range(20, 1)); i++) pkt.push_back($urandom);
            send_packet(20);
        end
        drain();
        full_mode = 0;
        check("rand_pkt_count", pkt_count, exp_pkts);
        check("rand_sat_err", sat_err, exp_sat);
        check("rand_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
